// File: rtl/trace_axis_packetizer.sv
// trace_axis_packetizer
// Buffers fixed-width trace packets in a FIFO and forwards them as an
// AXI4-Stream master. Frame ends are marked on a programmable beat interval
// or when the writer forces tlast.
// Optional feature macro: TRACE_AXIS_DROP_COUNTER_EN adds a saturating
// drop_count output that counts discarded writes.
module trace_axis_packetizer #(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write_enable,
  input  logic [DATA_WIDTH-1:0]       data_pkt,
  input  logic [31:0]                 tlast_interval,
  input  logic                        tlast,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [DATA_WIDTH-1:0]       M_AXIS_tdata,
  output logic                        M_AXIS_tlast,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
`ifdef TRACE_AXIS_DROP_COUNTER_EN
  ,
  output logic [31:0]                 drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] ONE_LEVEL  = LW'(1);
  localparam logic [LW-1:0] ZERO_LEVEL = {LW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [DATA_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         rd_ptr_inc_s;
  logic [LW-1:0]         level_r;
  logic [LW-1:0]         level_next_s;
  logic [31:0]           beat_count_r;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  interval_hit_s;
  logic                  last_flag_s;
  logic [DATA_WIDTH-1:0] head_data_next_s;
  logic                  head_last_next_s;

  // A write is taken when there is room, or when the head leaves in the same
  // cycle and frees a slot; only a write into a full, stalled FIFO is dropped.
  assign full_s         = (level_r == FULL_LEVEL);
  assign pop_s          = M_AXIS_tvalid & M_AXIS_tready;
  assign push_s         = write_enable & (~full_s | pop_s);
  assign drop_s         = write_enable & full_s & ~pop_s;
  assign interval_hit_s = (tlast_interval != 32'd0) &&
                          (beat_count_r >= (tlast_interval - 32'd1));
  assign last_flag_s    = tlast | interval_hit_s;
  assign rd_ptr_inc_s   = rd_ptr_r + PTR_ONE;
  assign fifo_level     = level_r;

  // Next occupancy from the push/pop combination.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + ONE_LEVEL;
      2'b01:   level_next_s = level_r - ONE_LEVEL;
      default: level_next_s = level_r;
    endcase
  end

  // Next head entry: bypass the incoming write when it becomes the head,
  // otherwise step to the following stored entry on a pop, or hold.
  always_comb begin
    head_data_next_s = M_AXIS_tdata;
    head_last_next_s = M_AXIS_tlast;
    if (level_next_s == ZERO_LEVEL) begin
      head_data_next_s = {DATA_WIDTH{1'b0}};
      head_last_next_s = 1'b0;
    end else if (pop_s) begin
      if (level_r == ONE_LEVEL) begin
        head_data_next_s = data_pkt;
        head_last_next_s = last_flag_s;
      end else begin
        head_data_next_s = mem_data_r[rd_ptr_inc_s];
        head_last_next_s = mem_last_r[rd_ptr_inc_s];
      end
    end else if (level_r == ZERO_LEVEL) begin
      head_data_next_s = data_pkt;
      head_last_next_s = last_flag_s;
    end else begin
      head_data_next_s = M_AXIS_tdata;
      head_last_next_s = M_AXIS_tlast;
    end
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_data_r[wr_ptr_r] <= data_pkt;
      mem_last_r[wr_ptr_r] <= last_flag_s;
    end
  end

  // Pointers, occupancy, beat counter and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      level_r       <= ZERO_LEVEL;
      beat_count_r  <= 32'd0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= {DATA_WIDTH{1'b0}};
      M_AXIS_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r     <= wr_ptr_r + PTR_ONE;
        beat_count_r <= last_flag_s ? 32'd0 : (beat_count_r + 32'd1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      level_r       <= level_next_s;
      M_AXIS_tvalid <= (level_next_s != ZERO_LEVEL);
      M_AXIS_tdata  <= head_data_next_s;
      M_AXIS_tlast  <= head_last_next_s;
      overflow      <= drop_s;
    end
  end

`ifdef TRACE_AXIS_DROP_COUNTER_EN
  // Saturating count of discarded writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= 32'd0;
    end else if (drop_s && (drop_count != 32'hFFFF_FFFF)) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_axis_packetizer.sv
// Directed testbench for trace_axis_packetizer (DATA_WIDTH=32, FIFO_DEPTH=16).
module tb_trace_axis_packetizer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_enable;
  logic [DW-1:0] data_pkt;
  logic [31:0]   tlast_interval;
  logic          tlast;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [DW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;
  logic [4:0]    fifo_level;
  logic          overflow;
`ifdef TRACE_AXIS_DROP_COUNTER_EN
  logic [31:0]   drop_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [32:0] q[$];
  logic [32:0] front;
  logic [32:0] junk;
  int nxt;

  always #5 clk = ~clk;

  trace_axis_packetizer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_enable   (write_enable),
    .data_pkt       (data_pkt),
    .tlast_interval (tlast_interval),
    .tlast          (tlast),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tlast   (M_AXIS_tlast),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
`ifdef TRACE_AXIS_DROP_COUNTER_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] v, input logic f);
    write_enable = 1'b1;
    data_pkt     = v;
    tlast        = f;
    step();
  endtask

  initial begin
    rst_n = 1'b0; write_enable = 1'b0; data_pkt = 32'd0;
    tlast_interval = 32'd0; tlast = 1'b0; M_AXIS_tready = 1'b0;
    step(); step();
    chk("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("rst_tdata", 64'(M_AXIS_tdata), 64'd0);
    chk("rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
`ifdef TRACE_AXIS_DROP_COUNTER_EN
    chk("rst_drop_count", 64'(drop_count), 64'd0);
`endif

    // Interval framing: 10 beats, interval 4
    rst_n = 1'b1; tlast_interval = 32'd4; M_AXIS_tready = 1'b1;
    step();
    chk("t1_pre_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      wr(32'(i), 1'b0);
      chk("t1_tvalid", 64'(M_AXIS_tvalid), 64'd1);
      chk("t1_tdata", 64'(M_AXIS_tdata), 64'(i));
      chk("t1_tlast", 64'(M_AXIS_tlast), 64'((i % 4) == 0));
      chk("t1_level", 64'(fifo_level), 64'd1);
    end
    write_enable = 1'b0;
    step();
    chk("t1_drained_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("t1_drained_tdata", 64'(M_AXIS_tdata), 64'd0);
    chk("t1_drained_level", 64'(fifo_level), 64'd0);

    // Forced tlast with interval off, then check the beat counter restarted
    tlast_interval = 32'd0;
    for (int i = 1; i <= 5; i++) begin
      wr(32'h20 + 32'(i), (i == 3));
      chk("t2_tdata", 64'(M_AXIS_tdata), 64'h20 + 64'(i));
      chk("t2_tlast", 64'(M_AXIS_tlast), 64'(i == 3));
    end
    tlast_interval = 32'd4;
    wr(32'h26, 1'b0);
    chk("t2_restart_b6", 64'(M_AXIS_tlast), 64'd0);
    wr(32'h27, 1'b0);
    chk("t2_restart_b7", 64'(M_AXIS_tlast), 64'd1);
    tlast_interval = 32'd1;
    wr(32'h28, 1'b0);
    chk("t2_int1_a", 64'(M_AXIS_tlast), 64'd1);
    wr(32'h29, 1'b0);
    chk("t2_int1_b", 64'(M_AXIS_tlast), 64'd1);
    write_enable = 1'b0; tlast = 1'b0;
    step();
    chk("t2_drained_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("t2_drained_level", 64'(fifo_level), 64'd0);

    // Overflow: 18 writes into a stalled 16-entry FIFO
    tlast_interval = 32'd0; M_AXIS_tready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      wr(32'(i), 1'b0);
      chk("t3_overflow", 64'(overflow), 64'(i > 16));
      chk("t3_level", 64'(fifo_level), 64'((i > 16) ? 16 : i));
      chk("t3_head_hold", 64'(M_AXIS_tdata), 64'd1);
    end
    write_enable = 1'b0;
    step();
    chk("t3_overflow_end", 64'(overflow), 64'd0);
    chk("t3_level_full", 64'(fifo_level), 64'd16);
    chk("t3_tvalid", 64'(M_AXIS_tvalid), 64'd1);
    chk("t3_head", 64'(M_AXIS_tdata), 64'd1);
`ifdef TRACE_AXIS_DROP_COUNTER_EN
    chk("t3_drop_count", 64'(drop_count), 64'd2);
`endif

    // Full + write + pop: write accepted, no overflow, then drain
    M_AXIS_tready = 1'b1;
    wr(32'd99, 1'b0);
    write_enable = 1'b0;
    chk("t4_overflow", 64'(overflow), 64'd0);
    chk("t4_level", 64'(fifo_level), 64'd16);
    chk("t4_head", 64'(M_AXIS_tdata), 64'd2);
    for (int k = 3; k <= 16; k++) begin
      step();
      chk("t4_drain", 64'(M_AXIS_tdata), 64'(k));
    end
    step();
    chk("t4_last_value", 64'(M_AXIS_tdata), 64'd99);
    chk("t4_last_level", 64'(fifo_level), 64'd1);
    step();
    chk("t4_empty_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("t4_empty_level", 64'(fifo_level), 64'd0);

    // Backpressure: random tready, values 0..31, queue model
    tlast_interval = 32'd0; nxt = 0;
    for (int cyc = 0; cyc < 400 && (nxt < 32 || q.size() != 0); cyc++) begin
      M_AXIS_tready = 1'($urandom_range(1, 0));
      if (nxt < 32 && q.size() < DEPTH) begin
        write_enable = 1'b1; data_pkt = 32'(nxt); tlast = ((nxt % 5) == 4);
      end else begin
        write_enable = 1'b0; tlast = 1'b0;
      end
      if (q.size() != 0 && M_AXIS_tready) junk = q.pop_front();
      if (write_enable) begin
        q.push_back({tlast, data_pkt});
        nxt++;
      end
      step();
      chk("bp_tvalid", 64'(M_AXIS_tvalid), 64'(q.size() != 0));
      chk("bp_level", 64'(fifo_level), 64'(q.size()));
      if (q.size() != 0) begin
        front = q[0];
        chk("bp_tdata", 64'(M_AXIS_tdata), 64'(front[31:0]));
        chk("bp_tlast", 64'(M_AXIS_tlast), 64'(front[32]));
      end
    end
    chk("bp_done", 64'(q.size() == 0 && nxt == 32), 64'd1);
    write_enable = 1'b0; tlast = 1'b0;

    // Mid-stream reset with 5 entries queued; write during reset is ignored
    M_AXIS_tready = 1'b0;
    for (int i = 1; i <= 5; i++) wr(32'h50 + 32'(i), 1'b0);
    chk("t6_level_5", 64'(fifo_level), 64'd5);
    rst_n = 1'b0; write_enable = 1'b1; data_pkt = 32'hEE;
    step();
    chk("t6_rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("t6_rst_tdata", 64'(M_AXIS_tdata), 64'd0);
    chk("t6_rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    rst_n = 1'b1; write_enable = 1'b0;
    step();
    chk("t6_post_level", 64'(fifo_level), 64'd0);
    chk("t6_post_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    M_AXIS_tready = 1'b1; tlast_interval = 32'd3;
    wr(32'h61, 1'b0);
    chk("t6_first_tvalid", 64'(M_AXIS_tvalid), 64'd1);
    chk("t6_first_tdata", 64'(M_AXIS_tdata), 64'h61);
    chk("t6_first_tlast", 64'(M_AXIS_tlast), 64'd0);
    wr(32'h62, 1'b0);
    chk("t6_b2_tlast", 64'(M_AXIS_tlast), 64'd0);
    wr(32'h63, 1'b0);
    chk("t6_b3_tlast", 64'(M_AXIS_tlast), 64'd1);

    // Lowering the interval below the beat count ends the frame at once
    tlast_interval = 32'd8;
    wr(32'h64, 1'b0);
    chk("t7_b1_tlast", 64'(M_AXIS_tlast), 64'd0);
    wr(32'h65, 1'b0);
    wr(32'h66, 1'b0);
    chk("t7_b3_tlast", 64'(M_AXIS_tlast), 64'd0);
    tlast_interval = 32'd2;
    wr(32'h67, 1'b0);
    chk("t7_lowered_tdata", 64'(M_AXIS_tdata), 64'h67);
    chk("t7_lowered_tlast", 64'(M_AXIS_tlast), 64'd1);
    write_enable = 1'b0;
    step();
    chk("t7_end_tvalid", 64'(M_AXIS_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
